traffic_mode_scheduler: RTL and testbench



---
 rtl/traffic_mode_scheduler.sv | 157 +++++++++++++++
 tb/tb_traffic_mode_scheduler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_mode_scheduler.sv
// Traffic mode scheduler: averages car-count samples per window, classifies flow with
// hysteresis and commits a new traffic_sel only at a safe Signal_CU phase boundary.
module traffic_mode_scheduler #(
   parameter int         CNT_W       = 8,
   parameter int         WIN_LOG2    = 3,
   parameter int         LOW_TH      = 4,
   parameter int         HIGH_TH     = 12,
   parameter int         HYST        = 2,
   parameter int         HOLD_PHASES = 2,
   parameter logic [1:0] SAFE_STATE  = 2'b00
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] i_car_cnt,
   input  logic             i_cnt_valid,
   output logic             o_cnt_ready,
   input  logic [1:0]       i_tr_state,
   input  logic             i_tr_valid,
   output logic [1:0]       o_traffic_sel,
   output logic             o_sel_update,
   output logic [CNT_W-1:0] o_avg,
   output logic             o_pending
);

   localparam int SUM_W  = CNT_W + WIN_LOG2;
   localparam int HOLD_W = (HOLD_PHASES < 1) ? 1 : $clog2(HOLD_PHASES + 1);

   localparam logic [1:0] ST_ACCUM = 2'd0;
   localparam logic [1:0] ST_EVAL  = 2'd1;
   localparam logic [1:0] ST_PEND  = 2'd2;

   localparam logic [1:0] MODE_NORMAL = 2'b00;
   localparam logic [1:0] MODE_LOW    = 2'b01;
   localparam logic [1:0] MODE_HIGH   = 2'b10;

   logic [1:0]          state_q, state_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [WIN_LOG2-1:0] cnt_q, cnt_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic [1:0]          cand_q, cand_d;
   logic [1:0]          sel_q, sel_d;
   logic                upd_q, upd_d;
   logic [CNT_W-1:0]    avg_q, avg_d;

   logic [CNT_W-1:0]    avg;
   int                  avgInt;
   logic [1:0]          cand;
   logic                accept;
   logic                commit;

   assign o_cnt_ready   = (state_q == ST_ACCUM) && reset;
   assign o_pending     = (state_q == ST_PEND);
   assign o_traffic_sel = sel_q;
   assign o_sel_update  = upd_q;
   assign o_avg         = avg_q;

   assign accept = i_cnt_valid && o_cnt_ready;
   assign commit = (state_q == ST_PEND) && i_tr_valid && (i_tr_state == SAFE_STATE);
   assign avg    = CNT_W'(sum_q >> WIN_LOG2);

   // Leaving LOW or HIGH needs the average to clear the threshold by HYST to avoid flapping.
   always_comb begin
      avgInt = int'(avg);
      cand   = sel_q;
      case (sel_q)
         MODE_LOW: begin
            if (avgInt > LOW_TH + HYST)
               cand = (avgInt >= HIGH_TH) ? MODE_HIGH : MODE_NORMAL;
         end
         MODE_HIGH: begin
            if (avgInt < HIGH_TH - HYST)
               cand = (avgInt <= LOW_TH) ? MODE_LOW : MODE_NORMAL;
         end
         default: begin
            if (avgInt <= LOW_TH)
               cand = MODE_LOW;
            else if (avgInt >= HIGH_TH)
               cand = MODE_HIGH;
            else
               cand = MODE_NORMAL;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      cand_d  = cand_q;
      sel_d   = sel_q;
      upd_d   = 1'b0;
      avg_d   = avg_q;
      hold_d  = hold_q;

      if (i_tr_valid && (hold_q != '0))
         hold_d = hold_q - 1'b1;

      case (state_q)
         ST_ACCUM: begin
            if (accept) begin
               sum_d = sum_q + SUM_W'(i_car_cnt);
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == '1)
                  state_d = ST_EVAL;
            end
         end
         ST_EVAL: begin
            avg_d = avg;
            if ((cand == sel_q) || (hold_q != '0)) begin
               sum_d   = '0;
               cnt_d   = '0;
               state_d = ST_ACCUM;
            end else begin
               cand_d  = cand;
               state_d = ST_PEND;
            end
         end
         ST_PEND: begin
            // The commit reload overrides any hold decrement in the same cycle.
            if (commit) begin
               sel_d   = cand_q;
               upd_d   = 1'b1;
               hold_d  = HOLD_W'(HOLD_PHASES);
               sum_d   = '0;
               cnt_d   = '0;
               state_d = ST_ACCUM;
            end
         end
         default: begin
            state_d = ST_ACCUM;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_ACCUM;
         sum_q   <= '0;
         cnt_q   <= '0;
         hold_q  <= '0;
         cand_q  <= MODE_NORMAL;
         sel_q   <= MODE_NORMAL;
         upd_q   <= 1'b0;
         avg_q   <= '0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         cand_q  <= cand_d;
         sel_q   <= sel_d;
         upd_q   <= upd_d;
         avg_q   <= avg_d;
      end
   end

endmodule

// File: tb/tb_traffic_mode_scheduler.sv
// Directed bench for traffic_mode_scheduler: expected averages and modes are queued
// when a window is driven and popped when the DUT evaluates or commits.
module tb_traffic_mode_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] carCnt;
   logic       cntValid;
   logic       cntReady;
   logic [1:0] trState;
   logic       trValid;
   logic [1:0] trafficSel;
   logic       selUpdate;
   logic [7:0] avgOut;
   logic       pending;

   int         testsRun = 0;
   int         testsFailed = 0;

   int         avgQ[$];
   logic [1:0] modeQ[$];
   logic [1:0] modeModel;
   int         holdModel;
   bit         pendModel;

   always #5 clk = ~clk;

   traffic_mode_scheduler dut (
      .clk           (clk),
      .reset         (reset),
      .i_car_cnt     (carCnt),
      .i_cnt_valid   (cntValid),
      .o_cnt_ready   (cntReady),
      .i_tr_state    (trState),
      .i_tr_valid    (trValid),
      .o_traffic_sel (trafficSel),
      .o_sel_update  (selUpdate),
      .o_avg         (avgOut),
      .o_pending     (pending)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Classification with hysteresis, written straight from the mode rules.
   function automatic logic [1:0] classify(input logic [1:0] cur, input int a);
      if (cur == 2'b01)
         return (a > 6) ? ((a >= 12) ? 2'b10 : 2'b00) : 2'b01;
      if (cur == 2'b10)
         return (a < 10) ? ((a <= 4) ? 2'b01 : 2'b00) : 2'b10;
      if (a <= 4) return 2'b01;
      if (a >= 12) return 2'b10;
      return 2'b00;
   endfunction

   task automatic doReset(input int cycles);
      reset    = 1'b0;
      cntValid = 1'b0;
      trValid  = 1'b0;
      for (int i = 0; i < cycles; i++) tick();
      modeModel = 2'b00;
      holdModel = 0;
      pendModel = 0;
      modeQ.delete();
      checkOutput("reset_sel", trafficSel, 2'b00);
      checkOutput("reset_update", selUpdate, 1'b0);
      checkOutput("reset_avg", avgOut, 0);
      checkOutput("reset_pending", pending, 1'b0);
      checkOutput("reset_ready_low", cntReady, 1'b0);
      reset = 1'b1;
      tick();
      checkOutput("ready_after_release", cntReady, 1'b1);
      checkOutput("no_update_after_reset", selUpdate, 1'b0);
   endtask

   // Feeds a full window through the valid/ready handshake starting at sample startIdx.
   task automatic applyStimulus(input int samples[8], input int startIdx, input bit keepValid, input int nextVal);
      int total = 0;
      int accepted = startIdx;
      int guard = 0;
      logic rdy;
      logic [1:0] cand;
      for (int i = 0; i < 8; i++) total += samples[i];
      avgQ.push_back(total >> 3);
      cand = classify(modeModel, total >> 3);
      pendModel = (cand != modeModel) && (holdModel == 0);
      if (pendModel) modeQ.push_back(cand);
      while (accepted < 8 && guard < 100) begin
         carCnt   = 8'(samples[accepted]);
         cntValid = 1'b1;
         rdy      = cntReady;
         tick();
         if (rdy) accepted++;
         guard++;
      end
      checkOutput("window_accepted", accepted, 8);
      if (keepValid) begin
         carCnt   = 8'(nextVal);
         cntValid = 1'b1;
      end else begin
         cntValid = 1'b0;
      end
      checkOutput("eval_ready_low", cntReady, 1'b0);
      tick();
      checkOutput("o_avg", avgOut, avgQ.pop_front());
      checkOutput("o_pending", pending, pendModel);
      checkOutput("sel_held", trafficSel, modeModel);
   endtask

   task automatic constWindow(input int v);
      int s[8];
      for (int i = 0; i < 8; i++) s[i] = v;
      applyStimulus(s, 0, 1'b0, 0);
   endtask

   task automatic phasePulse(input logic [1:0] st);
      bit commit;
      logic [1:0] expMode;
      commit  = pendModel && (st == 2'b00);
      trState = st;
      trValid = 1'b1;
      tick();
      trValid = 1'b0;
      if (commit) begin
         expMode   = modeQ.pop_front();
         modeModel = expMode;
         holdModel = 2;
         pendModel = 0;
         checkOutput("commit_sel", trafficSel, expMode);
         checkOutput("commit_update", selUpdate, 1'b1);
         checkOutput("commit_pending", pending, 1'b0);
         tick();
         checkOutput("update_one_cycle", selUpdate, 1'b0);
         checkOutput("ready_after_commit", cntReady, 1'b1);
      end else begin
         if (holdModel > 0) holdModel--;
         checkOutput("pulse_no_update", selUpdate, 1'b0);
         checkOutput("pulse_sel", trafficSel, modeModel);
         checkOutput("pulse_pending", pending, pendModel);
      end
   endtask

   initial begin
      int ramp[8];
      int tail[8];
      reset    = 1'b0;
      carCnt   = '0;
      cntValid = 1'b0;
      trState  = 2'b00;
      trValid  = 1'b0;
      doReset(3);

      // NORMAL to HIGH; a non-safe boundary must not commit.
      constWindow(15);
      phasePulse(2'b01);
      phasePulse(2'b00);

      // Hysteresis in HIGH once the hold has expired.
      phasePulse(2'b01);
      phasePulse(2'b01);
      constWindow(11);
      constWindow(9);
      phasePulse(2'b00);

      // Hold blocks a change right after a commit, then releases after two phases.
      constWindow(2);
      phasePulse(2'b01);
      phasePulse(2'b01);
      constWindow(2);
      phasePulse(2'b00);

      // Back to NORMAL so the ramp window yields a LOW candidate.
      phasePulse(2'b01);
      phasePulse(2'b01);
      constWindow(8);
      phasePulse(2'b00);
      phasePulse(2'b01);
      phasePulse(2'b01);

      // Backpressure: valid stays high through EVAL/PEND with the ninth sample parked.
      for (int i = 0; i < 8; i++) ramp[i] = i;
      applyStimulus(ramp, 0, 1'b1, 28);
      checkOutput("pend_ready_low", cntReady, 1'b0);
      phasePulse(2'b01);
      checkOutput("pend_ready_still_low", cntReady, 1'b0);
      phasePulse(2'b00);
      tail[0] = 28;
      for (int i = 1; i < 8; i++) tail[i] = 20;
      applyStimulus(tail, 1, 1'b0, 0);

      // Reset while PEND discards the pending HIGH without an update pulse.
      phasePulse(2'b01);
      phasePulse(2'b01);
      constWindow(15);
      doReset(1);
      constWindow(0);
      phasePulse(2'b00);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
